backprop_unit: RTL and testbench
================================

BACKPROP_UNIT -- requirements
Module: backprop_unit

Interface
REQ-001 Parameter WW, default 8: signed weight width.
REQ-002 Parameter WX, default 10: unsigned hidden-activation width.
REQ-003 Parameter WE, default 12: signed error width.
REQ-004 Parameter LR_SHIFT, default 6: learning-rate right-shift.
REQ-005 Parameter CLIP, default 16: gradient clip magnitude, used only under GRAD_CLIP_EN.
REQ-006 Port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-007 Port rst_i, input, 1: reset; synchronous and active-high.
REQ-008 Port start_i, input, 1: single-cycle pulse, driven from the state machine's b_pass_o, that begins one update pass.
REQ-009 Port err_i, input, WE: signed output error (target minus final output).
REQ-010 Port act_idx_o, output, 3: index of the hidden activation requested.
REQ-011 Port act_i, input, WX: hidden activation selected by act_idx_o, valid in the same cycle.
REQ-012 Port load_i, input, 1: writes load_data_i to weight load_idx_i.
REQ-013 Port load_idx_i, input, 3: weight index for load_i.
REQ-014 Port load_data_i, input, WW: signed weight value for load_i.
REQ-015 Port w_flat_o, output, 8*WW: all eight weights, with weight k at bits [k*WW +: WW].
REQ-016 Port busy_o, output, 1: high while an update pass is in progress.
REQ-017 Port done_o, output, 1: one-cycle pulse at the end of a pass.

Function
REQ-018 The state machine SHALL have states IDLE, MUL, UPD and DONE.
REQ-019 Transitions: IDLE->MUL on an accepted start; MUL->UPD always; UPD->MUL while idx<7; UPD->DONE at idx=7; DONE->IDLE always.
REQ-020 On an accepted start, err_i SHALL be captured into an internal register, and idx SHALL be set to 0.
REQ-021 In MUL, act_idx_o=idx, and prod = err_reg * {0,act_i} SHALL be registered at full width WE+WX+1, signed.
REQ-022 In UPD, delta = prod >>> LR_SHIFT, using arithmetic shift (floor rounding).
REQ-023 In UPD, weight[idx] = sat(weight[idx] + delta), saturated to [-2^(WW-1), 2^(WW-1)-1]; idx then increments.
REQ-024 Timing: start accepted at edge k -> busy_o high for cycles k+1..k+16 -> done_o high only in cycle k+17.
REQ-025 w_flat_o SHALL reflect registered weights only; a weight changes on its UPD edge and at no other time during a pass.
REQ-026 start_i while busy_o or done_o is high SHALL be ignored.
REQ-027 load_i while busy_o is high SHALL be ignored.
REQ-028 load_i in IDLE SHALL write on the next edge.
REQ-029 Simultaneous load_i and start_i in IDLE: the load SHALL be applied and the start dropped.
REQ-030 err_i changes after capture SHALL have no effect on the current pass.
REQ-031 err_reg=0 SHALL still run the full 17-cycle sequence, with weights unchanged.
REQ-032 act_idx_o SHALL be 0 whenever the state is not MUL.

Reset
REQ-033 rst_i high at any edge, including mid-pass, SHALL force IDLE, idx=0, err_reg=0, prod=0, busy_o=0, done_o=0 and act_idx_o=0.
REQ-034 On that same reset edge, weight k SHALL return to k+1 (1..8); the interrupted pass is abandoned with no done_o.

Configuration
REQ-035 With macro GRAD_CLIP_EN defined, delta SHALL be clamped to [-CLIP, +CLIP] before the saturating add.
REQ-036 Without GRAD_CLIP_EN, delta SHALL be used unclamped; no clip logic SHALL be present.

Structure
REQ-037 Package nn_pkg SHALL hold: the default widths, the default LR_SHIFT, the state enum (IDLE/MUL/UPD/DONE), and the reset weight constant table 1..8.
REQ-038 Sub-module sat_add SHALL perform the parameterised signed add with saturation to WW; one instance is used.

Verification
REQ-039 Reset, then w0 reset value, err_i=64, act0=64, start -> w0=1+64=65 and done_o at cycle k+17.
REQ-040 Load w3=120, act3=1023, err_i=2047 -> w3=127 (saturated); load w3=-120 with err_i=-2048 -> w3=-128.
REQ-041 err_i=-1, all acts=1 -> every weight decremented by 1 (floor), giving weights 0..7.
REQ-042 start_i re-pulsed at cycle k+5, and load_i at k+8 -> both ignored, and a single done_o at k+17.
REQ-043 rst_i asserted at cycle k+9 -> IDLE, weights 1..8, busy_o=0, and no done_o.
REQ-044 GRAD_CLIP_EN defined with the REQ-039 stimulus -> w0=1+16=17; GRAD_CLIP_EN undefined -> w0=65.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the backprop update slice: default widths, the pass
// state machine encoding and the weight values restored on reset.
package nn_pkg;

    localparam int unsigned DEF_WW       = 8;
    localparam int unsigned DEF_WX       = 10;
    localparam int unsigned DEF_WE       = 12;
    localparam int unsigned DEF_LR_SHIFT = 6;
    localparam int unsigned DEF_CLIP     = 16;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StUpd,
        StDone
    } state_e;

    // Weight k comes out of reset as k+1.
    localparam int RESET_W [8] = '{1, 2, 3, 4, 5, 6, 7, 8};

endpackage

// File: rtl/backprop_unit_if.sv
// Handshake and data bus between the update unit and its controller.
// master: controller side (drives start/error/activation/load); slave: the unit.
interface backprop_unit_if #(
    parameter int unsigned WW = nn_pkg::DEF_WW,
    parameter int unsigned WX = nn_pkg::DEF_WX,
    parameter int unsigned WE = nn_pkg::DEF_WE
);

    logic                 start_i;
    logic signed [WE-1:0] err_i;
    logic [2:0]           act_idx_o;
    logic [WX-1:0]        act_i;
    logic                 load_i;
    logic [2:0]           load_idx_i;
    logic signed [WW-1:0] load_data_i;
    logic [8*WW-1:0]      w_flat_o;
    logic                 busy_o;
    logic                 done_o;

    modport master (
        output start_i, err_i, act_i, load_i, load_idx_i, load_data_i,
        input  act_idx_o, w_flat_o, busy_o, done_o
    );

    modport slave (
        input  start_i, err_i, act_i, load_i, load_idx_i, load_data_i,
        output act_idx_o, w_flat_o, busy_o, done_o
    );

endinterface

// File: rtl/sat_add.sv
// Signed add of a WA-bit value and a WB-bit increment, saturated to WA bits.
module sat_add #(
    parameter int unsigned WA = 8,
    parameter int unsigned WB = 8
) (
    input  logic signed [WA-1:0] a_i,
    input  logic signed [WB-1:0] b_i,
    output logic signed [WA-1:0] sum_o
);

    // One guard bit above the wider operand so the raw sum never wraps.
    localparam int unsigned WS = ((WA > WB) ? WA : WB) + 1;
    localparam logic signed [WS-1:0] MaxV = {{(WS - WA + 1){1'b0}}, {(WA - 1){1'b1}}};
    localparam logic signed [WS-1:0] MinV = {{(WS - WA + 1){1'b1}}, {(WA - 1){1'b0}}};

    logic signed [WS-1:0] sum_full;

    assign sum_full = {{(WS - WA){a_i[WA-1]}}, a_i} + {{(WS - WB){b_i[WB-1]}}, b_i};

    // Clamp the wide sum into the representable weight range.
    always_comb begin
        sum_o = sum_full[WA-1:0];
        if (sum_full > MaxV) begin
            sum_o = MaxV[WA-1:0];
        end else if (sum_full < MinV) begin
            sum_o = MinV[WA-1:0];
        end
    end

endmodule

// File: rtl/backprop_unit.sv
// Output-layer weight update: walks the eight weights, forms err*act, scales
// by the learning-rate shift and saturating-adds the result into each weight.
// Optional feature macro: GRAD_CLIP_EN clamps each delta to [-CLIP, +CLIP].
module backprop_unit
    import nn_pkg::*;
#(
    parameter int unsigned WW       = DEF_WW,
    parameter int unsigned WX       = DEF_WX,
    parameter int unsigned WE       = DEF_WE,
    parameter int unsigned LR_SHIFT = DEF_LR_SHIFT,
    parameter int unsigned CLIP     = DEF_CLIP
) (
    input logic              clk_i,
    input logic              rst_i,
    backprop_unit_if.slave   bus_io
);

    localparam int unsigned WP = WE + WX + 1;
    localparam int unsigned WD = WP - LR_SHIFT;

    state_e               state_q, state_d;
    logic [2:0]           idx_q;
    logic signed [WE-1:0] err_q;
    logic signed [WP-1:0] prod_q, prod_d;
    logic signed [WW-1:0] w_q [8];
    logic signed [WD-1:0] delta_raw, delta;
    logic signed [WW-1:0] w_sum;
    logic [8*WW-1:0]      w_flat;
    logic                 busy, start_ok, load_ok;

    assign busy     = (state_q == StMul) || (state_q == StUpd);
    // A load in the same cycle as a start wins; the start is dropped.
    assign start_ok = (state_q == StIdle) && bus_io.start_i && !bus_io.load_i;
    assign load_ok  = !busy && bus_io.load_i;

    // Next-state logic for the pass sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok) state_d = StMul;
            StMul:   state_d = StUpd;
            StUpd:   state_d = (idx_q == 3'd7) ? StDone : StMul;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state, weight index and captured error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                err_q <= bus_io.err_i;
                idx_q <= '0;
            end else if (state_q == StUpd) begin
                idx_q <= idx_q + 3'd1;
            end
        end
    end

    // Activation is unsigned: zero-extend it, sign-extend the error; the low
    // WP bits of the unsigned product are the exact two's-complement result.
    assign prod_d = {{(WP - WE){err_q[WE-1]}}, err_q} * {{(WP - WX){1'b0}}, bus_io.act_i};

    // Product register, loaded only during MUL.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prod_q <= '0;
        end else if (state_q == StMul) begin
            prod_q <= prod_d;
        end
    end

    // Dropping the low bits is an arithmetic shift with floor rounding.
    assign delta_raw = prod_q[WP-1:LR_SHIFT];

    // Optional gradient clamp ahead of the saturating add.
    always_comb begin
        delta = delta_raw;
`ifdef GRAD_CLIP_EN
        if (delta_raw > $signed(WD'(CLIP))) begin
            delta = WD'(CLIP);
        end else if (delta_raw < -$signed(WD'(CLIP))) begin
            delta = -$signed(WD'(CLIP));
        end
`endif
    end

    sat_add #(
        .WA (WW),
        .WB (WD)
    ) u_sat_add (
        .a_i   (w_q[idx_q]),
        .b_i   (delta),
        .sum_o (w_sum)
    );

    // Weight bank: reset table, UPD write-back, or an idle-time load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < 8; k++) begin
                w_q[k] <= WW'(RESET_W[k]);
            end
        end else if (state_q == StUpd) begin
            w_q[idx_q] <= w_sum;
        end else if (load_ok) begin
            w_q[bus_io.load_idx_i] <= bus_io.load_data_i;
        end
    end

    // Pack the registered weights onto the flat output bus.
    always_comb begin
        w_flat = '0;
        for (int k = 0; k < 8; k++) begin
            w_flat[k*WW +: WW] = w_q[k];
        end
    end

    assign bus_io.w_flat_o  = w_flat;
    assign bus_io.busy_o    = busy;
    assign bus_io.done_o    = (state_q == StDone);
    assign bus_io.act_idx_o = (state_q == StMul) ? idx_q : 3'd0;

    // Shifted-out product bits, and CLIP when clamping is compiled out.
    logic unused_bits;
    assign unused_bits = ^{prod_q[LR_SHIFT-1:0], CLIP};

endmodule

// File: tb/tb_backprop_unit.sv
// Bench for backprop_unit: table of update passes with a weight scoreboard,
// plus hand sequences for reset state and the load/start collision.
module tb_backprop_unit;
    import nn_pkg::*;

    localparam int unsigned WW = 8;
    localparam int unsigned WX = 10;
    localparam int unsigned WE = 12;
`ifdef GRAD_CLIP_EN
    localparam int W0 = 17;
`else
    localparam int W0 = 65;
`endif

    typedef struct {
        bit              rst_before;
        bit              ld;
        int              ld_idx;
        int              ld_data;
        int              err;
        logic [7:0][9:0] act;
        int              start_c;
        int              load_c;
        int              rst_c;
        logic [7:0][7:0] exp_w;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    backprop_unit_if #(.WW(WW), .WX(WX), .WE(WE)) bus ();

    backprop_unit #(
        .WW       (WW),
        .WX       (WX),
        .WE       (WE),
        .LR_SHIFT (6),
        .CLIP     (16)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    logic [7:0][9:0] acts;
    assign bus.act_i = acts[bus.act_idx_o];

    logic [63:0] sb_q [$];
    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    function automatic logic [7:0][7:0] w8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [7:0][7:0] r;
        r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
        r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7);
        return r;
    endfunction

    function automatic logic [7:0][9:0] act_one(input int idx, input int val);
        logic [7:0][9:0] r;
        r = '0;
        r[idx] = 10'(val);
        return r;
    endfunction

    function automatic logic [7:0][9:0] act_all(input int val);
        logic [7:0][9:0] r;
        for (int k = 0; k < 8; k++) r[k] = 10'(val);
        return r;
    endfunction

    function automatic vec_t mk(input bit rb, input bit ld, input int li, input int ldd,
                                input int err, input logic [7:0][9:0] a, input int sc,
                                input int lc, input int rc, input logic [7:0][7:0] w);
        vec_t v;
        v.rst_before = rb; v.ld = ld; v.ld_idx = li; v.ld_data = ldd; v.err = err;
        v.act = a; v.start_c = sc; v.load_c = lc; v.rst_c = rc; v.exp_w = w;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One update pass; cycle c counts from 1 right after the accepting edge.
    task automatic run_pass(input int n, input vec_t v);
        int busy_bad = 0;
        int done_bad = 0;
        int idx_bad = 0;
        int lim;
        logic [63:0] want;
        lim = (v.rst_c != 0) ? v.rst_c : 16;
        if (v.rst_before) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
        end
        if (v.ld) begin
            bus.load_i = 1'b1;
            bus.load_idx_i = 3'(v.ld_idx);
            bus.load_data_i = 8'(v.ld_data);
            step();
            bus.load_i = 1'b0;
        end
        acts = v.act;
        bus.err_i = 12'(v.err);
        bus.start_i = 1'b1;
        sb_q.push_back(v.exp_w);
        step();
        bus.start_i = 1'b0;
        bus.err_i = 12'($urandom);
        for (int c = 1; c <= 24; c++) begin
            if (bus.busy_o !== ((c <= lim) ? 1'b1 : 1'b0)) busy_bad++;
            if (bus.done_o !== ((v.rst_c == 0 && c == 17) ? 1'b1 : 1'b0)) done_bad++;
            if (bus.act_idx_o !== ((c <= lim && (c % 2) == 1) ? 3'((c - 1) / 2) : 3'd0))
                idx_bad++;
            if (bus.done_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check($sformatf("v%0d extra_done", n), 64'd1, 64'd0);
                end else begin
                    want = sb_q.pop_front();
                    check($sformatf("v%0d weights", n), bus.w_flat_o, want);
                end
            end
            if (c == v.start_c) bus.start_i = 1'b1;
            if (c == v.load_c) begin
                bus.load_i = 1'b1;
                bus.load_idx_i = 3'd0;
                bus.load_data_i = 8'sd99;
            end
            if (c == v.rst_c) rst = 1'b1;
            step();
            bus.start_i = 1'b0;
            bus.load_i = 1'b0;
            rst = 1'b0;
        end
        if (v.rst_c != 0 && sb_q.size() != 0) begin
            want = sb_q.pop_front();
            check($sformatf("v%0d abort_weights", n), bus.w_flat_o, want);
        end
        check($sformatf("v%0d busy_seq", n), 64'(busy_bad), 64'd0);
        check($sformatf("v%0d done_seq", n), 64'(done_bad), 64'd0);
        check($sformatf("v%0d act_idx_seq", n), 64'(idx_bad), 64'd0);
        check($sformatf("v%0d sb_drained", n), 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    initial begin
        int busy_seen;
        int done_seen;
        vecs[0] = mk(1, 0, 0, 0, 64, act_one(0, 64), 0, 0, 0, w8(W0, 2, 3, 4, 5, 6, 7, 8));
        vecs[1] = mk(0, 1, 3, 120, 2047, act_one(3, 1023), 0, 0, 0,
                     w8(W0, 2, 3, 127, 5, 6, 7, 8));
        vecs[2] = mk(0, 1, 3, -120, -2048, act_one(3, 1023), 0, 0, 0,
                     w8(W0, 2, 3, -128, 5, 6, 7, 8));
        vecs[3] = mk(1, 0, 0, 0, -1, act_all(1), 0, 0, 0, w8(0, 1, 2, 3, 4, 5, 6, 7));
        vecs[4] = mk(0, 0, 0, 0, 0, act_all(1023), 0, 0, 0, w8(0, 1, 2, 3, 4, 5, 6, 7));
        // -3*100 = -300, floor(-300/64) = -5
        vecs[5] = mk(0, 0, 0, 0, -3, act_all(100), 5, 8, 0, w8(-5, -4, -3, -2, -1, 0, 1, 2));
        vecs[6] = mk(0, 0, 0, 0, 64, act_all(64), 0, 0, 9, w8(1, 2, 3, 4, 5, 6, 7, 8));

        rst = 1'b1;
        acts = '0;
        bus.start_i = 1'b0;
        bus.err_i = '0;
        bus.load_i = 1'b0;
        bus.load_idx_i = '0;
        bus.load_data_i = '0;
        step();
        step();
        rst = 1'b0;
        check("reset busy", 64'(bus.busy_o), 64'd0);
        check("reset done", 64'(bus.done_o), 64'd0);
        check("reset act_idx", 64'(bus.act_idx_o), 64'd0);
        check("reset weights", bus.w_flat_o, w8(1, 2, 3, 4, 5, 6, 7, 8));

        for (int i = 0; i < 7; i++) begin
            run_pass(i, vecs[i]);
        end

        // Load and start together in idle: load lands, start is dropped.
        acts = act_all(64);
        bus.err_i = 12'sd64;
        bus.start_i = 1'b1;
        bus.load_i = 1'b1;
        bus.load_idx_i = 3'd5;
        bus.load_data_i = 8'sd42;
        step();
        bus.start_i = 1'b0;
        bus.load_i = 1'b0;
        busy_seen = 0;
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.busy_o === 1'b1) busy_seen++;
            if (bus.done_o === 1'b1) done_seen++;
            step();
        end
        check("collide busy", 64'(busy_seen), 64'd0);
        check("collide done", 64'(done_seen), 64'd0);
        check("collide weights", bus.w_flat_o, w8(1, 2, 3, 4, 5, 42, 7, 8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
